// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: load/store kinds from the decoder
// and the LSU handshake state machine.
package mem_stage_lsu_pkg;

  localparam logic [3:0] LOAD_NONE = 4'd0;
  localparam logic [3:0] LOAD_LB   = 4'd1;
  localparam logic [3:0] LOAD_LBU  = 4'd2;
  localparam logic [3:0] LOAD_LH   = 4'd3;
  localparam logic [3:0] LOAD_LHU  = 4'd4;
  localparam logic [3:0] LOAD_LW   = 4'd5;

  localparam logic [3:0] STORE_NONE = 4'd0;
  localparam logic [3:0] STORE_SB   = 4'd1;
  localparam logic [3:0] STORE_SH   = 4'd2;
  localparam logic [3:0] STORE_SW   = 4'd3;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_WAIT  = 3'd2,
    LSU_DONE  = 3'd3,
    LSU_DRAIN = 3'd4
  } lsu_state_e;

  // Replicate the store operand into every lane; the strobes pick the live ones.
  function automatic logic [31:0] lsu_store_lanes(input logic [3:0] st, input logic [31:0] sd);
    logic [31:0] lanes;
    case (st)
      STORE_SB:             lanes = {4{sd[7:0]}};
      STORE_SH:             lanes = {2{sd[15:0]}};
      STORE_SW, STORE_NONE: lanes = sd;
      default:              lanes = sd;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational byte/half/word extraction and sign/zero extension of bus read data.
module lsu_load_ext
  import mem_stage_lsu_pkg::*;
(
  input  logic [3:0]  load_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s = 8'h00;
    half_s = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result = 32'h0000_0000;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    case (load_type)
      LOAD_LB:  result = {{24{byte_s[7]}}, byte_s};
      LOAD_LBU: result = {24'h00_0000, byte_s};
      LOAD_LH:  result = {{16{half_s[15]}}, half_s};
      LOAD_LHU: result = {16'h0000, half_s};
      LOAD_LW:  result = rdata;
      default:  result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/addr_ok/data_ok bus transaction per memory instruction,
// stalling the pipeline until the access completes and holding extended load data in DONE.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wmem,
  input  logic [3:0]        load_type,
  input  logic [3:0]        store_type,
  input  logic [3:0]        byte_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              exc_pending,
  input  logic              flush,
  input  logic              pipe_adv,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_result
);

  lsu_state_e        state_q, state_d;
  logic              access_s;
  logic              word_s;
  logic              iss_wr_s;
  logic [3:0]        iss_wstrb_s;
  logic [ADDR_W-1:0] iss_addr_s;
  logic [DATA_W-1:0] iss_wdata_s;
  logic              bus_wr_q, bus_wr_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]        ld_type_q, ld_type_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [DATA_W-1:0] load_result_q, load_result_d;
  logic [DATA_W-1:0] ext_s;

  // Extraction uses the load kind and offset latched at issue, not the live EXE/MEM fields.
  lsu_load_ext u_load_ext (
    .load_type (ld_type_q),
    .addr_lo   (addr_lo_q),
    .rdata     (bus_rdata),
    .result    (ext_s)
  );

  always_comb begin
    access_s    = (wmem | (load_type != LOAD_NONE)) & ~exc_pending & ~flush & ~rst;
    word_s      = (load_type == LOAD_LW) | (wmem & (store_type == STORE_SW));
    iss_wr_s    = wmem;
    iss_wstrb_s = wmem ? byte_valid : 4'b0000;
    iss_addr_s  = word_s ? {addr[ADDR_W-1:2], 2'b00} : addr;
    iss_wdata_s = wmem ? lsu_store_lanes(store_type, store_data) : {DATA_W{1'b0}};
  end

  always_comb begin
    state_d       = state_q;
    bus_req       = 1'b0;
    bus_wr        = 1'b0;
    bus_wstrb     = 4'b0000;
    bus_addr      = {ADDR_W{1'b0}};
    bus_wdata     = {DATA_W{1'b0}};
    mem_stall     = 1'b0;
    bus_wr_d      = bus_wr_q;
    bus_wstrb_d   = bus_wstrb_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    ld_type_d     = ld_type_q;
    addr_lo_d     = addr_lo_q;
    load_result_d = load_result_q;
    case (state_q)
      LSU_IDLE: begin
        if (access_s) begin
          // Request goes out the same cycle the instruction is seen; the bus set is latched
          // so REQ can hold it stable while addr_ok is pending.
          bus_req     = 1'b1;
          bus_wr      = iss_wr_s;
          bus_wstrb   = iss_wstrb_s;
          bus_addr    = iss_addr_s;
          bus_wdata   = iss_wdata_s;
          mem_stall   = 1'b1;
          bus_wr_d    = iss_wr_s;
          bus_wstrb_d = iss_wstrb_s;
          bus_addr_d  = iss_addr_s;
          bus_wdata_d = iss_wdata_s;
          ld_type_d   = wmem ? LOAD_NONE : load_type;
          addr_lo_d   = addr[1:0];
          state_d     = bus_addr_ok ? LSU_WAIT : LSU_REQ;
        end else begin
          state_d = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (flush) begin
          state_d = LSU_IDLE;
        end else begin
          bus_req   = 1'b1;
          bus_wr    = bus_wr_q;
          bus_wstrb = bus_wstrb_q;
          bus_addr  = bus_addr_q;
          bus_wdata = bus_wdata_q;
          mem_stall = 1'b1;
          state_d   = bus_addr_ok ? LSU_WAIT : LSU_REQ;
        end
      end
      LSU_WAIT: begin
        mem_stall = ~flush;
        if (bus_data_ok) begin
          if (flush) begin
            state_d = LSU_IDLE;
          end else begin
            load_result_d = (ld_type_q != LOAD_NONE) ? ext_s : load_result_q;
            state_d       = LSU_DONE;
          end
        end else begin
          state_d = flush ? LSU_DRAIN : LSU_WAIT;
        end
      end
      LSU_DONE: begin
        state_d = (pipe_adv | flush) ? LSU_IDLE : LSU_DONE;
      end
      LSU_DRAIN: begin
        // The killed access still owes a data_ok; a waiting instruction must not issue yet.
        mem_stall = access_s;
        state_d   = bus_data_ok ? LSU_IDLE : LSU_DRAIN;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LSU_IDLE;
      bus_wr_q      <= 1'b0;
      bus_wstrb_q   <= 4'b0000;
      bus_addr_q    <= {ADDR_W{1'b0}};
      bus_wdata_q   <= {DATA_W{1'b0}};
      ld_type_q     <= LOAD_NONE;
      addr_lo_q     <= 2'b00;
      load_result_q <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      bus_wr_q      <= bus_wr_d;
      bus_wstrb_q   <= bus_wstrb_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      ld_type_q     <= ld_type_d;
      addr_lo_q     <= addr_lo_d;
      load_result_q <= load_result_d;
    end
  end

  assign load_result = load_result_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized bench for mem_stage_lsu against a transaction-level reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        wmem;
  logic [3:0]  load_type, store_type, byte_valid;
  logic [31:0] addr, store_data;
  logic        exc_pending, flush, pipe_adv;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        mem_stall;
  logic [31:0] load_result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_lr;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .wmem(wmem), .load_type(load_type), .store_type(store_type),
    .byte_valid(byte_valid), .addr(addr), .store_data(store_data), .exc_pending(exc_pending),
    .flush(flush), .pipe_adv(pipe_adv), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .mem_stall(mem_stall), .load_result(load_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wmem = 1'b0; load_type = 4'd0; store_type = 4'd0; byte_valid = 4'd0;
    addr = 32'd0; store_data = 32'd0; exc_pending = 1'b0; flush = 1'b0; pipe_adv = 1'b1;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
  endtask

  // Reference extraction: shift the selected lane down, then extend arithmetically.
  function automatic logic [31:0] ref_ext(input logic [3:0] lt, input logic [31:0] a,
                                          input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'h0000_00FF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
    case (lt)
      4'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      4'd4:    return h;
      4'd5:    return rd;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] stt, input logic [31:0] sd);
    case (stt)
      4'd1:    return (sd & 32'h0000_00FF) * 32'h0101_0101;
      4'd2:    return (sd & 32'h0000_FFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  // One memory instruction: issue at cycle 0, addr_ok at cycle adly, data_ok adly+1+ddly,
  // then DONE for hold+1 cycles with pipe_adv on the last one.
  task automatic run_txn(input logic st, input logic [3:0] lt, input logic [3:0] stt,
                         input logic [3:0] bv, input logic [31:0] a, input logic [31:0] sd,
                         input int adly, input int ddly, input logic [31:0] rd, input int hold);
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    int          dcyc, ncyc;
    e_addr  = ((!st && lt == 4'd5) || (st && stt == 4'd3)) ? (a & 32'hFFFF_FFFC) : a;
    e_wstrb = st ? bv : 4'd0;
    e_wdata = st ? ref_wdata(stt, sd) : 32'd0;
    dcyc    = adly + 1 + ddly;
    ncyc    = dcyc + 2 + hold;
    wmem = st; load_type = st ? 4'd0 : lt; store_type = st ? stt : 4'd0;
    byte_valid = bv; addr = a; store_data = sd; exc_pending = 1'b0; flush = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      bus_addr_ok = (c == adly);
      bus_data_ok = (c == dcyc);
      bus_rdata   = (c == dcyc) ? rd : $urandom;
      pipe_adv    = (c == ncyc - 1);
      #1;
      chk("req", {31'd0, bus_req}, {31'd0, c <= adly});
      chk("stall", {31'd0, mem_stall}, {31'd0, c <= dcyc});
      chk("load_result", load_result, model_lr);
      if (c <= adly) begin
        chk("addr", bus_addr, e_addr);
        chk("wr", {31'd0, bus_wr}, {31'd0, st});
        chk("wstrb", {28'd0, bus_wstrb}, {28'd0, e_wstrb});
        chk("wdata", bus_wdata, e_wdata);
      end
      step();
      if (c == dcyc && !st) model_lr = ref_ext(lt, a, rd);
    end
    set_idle();
  endtask

  initial begin
    logic        r_st;
    logic [3:0]  r_lt, r_stt, r_bv;
    logic [31:0] r_a;
    int          off;
    set_idle();
    rst = 1'b1;
    model_lr = 32'd0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wr", {31'd0, bus_wr}, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_load_result", load_result, 32'd0);

    // Fastest LW: two stall cycles.
    run_txn(1'b0, 4'd5, 4'd0, 4'hF, 32'h0000_0100, 32'd0, 0, 0, 32'h8765_4321, 0);
    #1 chk("lw_value", load_result, 32'h8765_4321);
    run_txn(1'b0, 4'd1, 4'd0, 4'h8, 32'h0000_0103, 32'd0, 0, 1, 32'h80FF_FFFF, 0);
    #1 chk("lb_value", load_result, 32'hFFFF_FF80);
    run_txn(1'b0, 4'd2, 4'd0, 4'h8, 32'h0000_0103, 32'd0, 1, 0, 32'h80FF_FFFF, 0);
    #1 chk("lbu_value", load_result, 32'h0000_0080);
    // SH with addr_ok delayed three cycles; bus fields checked every cycle of the hold.
    run_txn(1'b1, 4'd0, 4'd2, 4'b1100, 32'h0000_0202, 32'h0000_BEEF, 3, 1, 32'd0, 0);
    // DONE held for four cycles with pipe_adv low.
    run_txn(1'b0, 4'd4, 4'd0, 4'h3, 32'h0000_0010, 32'd0, 0, 0, 32'h1234_F00D, 4);
    #1 chk("lhu_value", load_result, 32'h0000_F00D);

    // Exception pending: no access at all.
    step();
    load_type = 4'd5; addr = 32'h0000_0500; exc_pending = 1'b1; pipe_adv = 1'b0;
    #1;
    chk("exc_req", {31'd0, bus_req}, 32'd0);
    chk("exc_stall", {31'd0, mem_stall}, 32'd0);
    step();
    chk("exc_req2", {31'd0, bus_req}, 32'd0);
    set_idle();
    step();

    // Flush in WAIT -> DRAIN; the late data_ok is discarded and the next load waits.
    load_type = 4'd5; addr = 32'h0000_0300; pipe_adv = 1'b0; bus_addr_ok = 1'b1;
    #1 chk("fl_issue_req", {31'd0, bus_req}, 32'd1);
    step();
    bus_addr_ok = 1'b0; flush = 1'b1;
    #1 chk("fl_wait_req", {31'd0, bus_req}, 32'd0);
    step();
    flush = 1'b0; addr = 32'h0000_0304;
    #1;
    chk("drain_req", {31'd0, bus_req}, 32'd0);
    chk("drain_stall", {31'd0, mem_stall}, 32'd1);
    step();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drain_req2", {31'd0, bus_req}, 32'd0);
    chk("drain_stall2", {31'd0, mem_stall}, 32'd1);
    step();
    bus_data_ok = 1'b0;
    chk("drain_discard", load_result, model_lr);
    run_txn(1'b0, 4'd5, 4'd0, 4'hF, 32'h0000_0304, 32'd0, 0, 0, 32'hCAFE_0001, 0);

    // Flush while still in REQ drops the request immediately.
    load_type = 4'd3; addr = 32'h0000_0402; pipe_adv = 1'b0;
    #1 chk("rq_issue_req", {31'd0, bus_req}, 32'd1);
    step();
    flush = 1'b1;
    #1 chk("rq_flush_req", {31'd0, bus_req}, 32'd0);
    step();
    set_idle();
    #1;
    chk("rq_after_req", {31'd0, bus_req}, 32'd0);
    chk("rq_after_stall", {31'd0, mem_stall}, 32'd0);
    step();

    // Reset mid-transaction returns straight to an idle, cleared unit.
    load_type = 4'd5; addr = 32'h0000_0600; pipe_adv = 1'b0; bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    set_idle();
    model_lr = 32'd0;
    #1;
    chk("mrst_req", {31'd0, bus_req}, 32'd0);
    chk("mrst_stall", {31'd0, mem_stall}, 32'd0);
    chk("mrst_load_result", load_result, 32'd0);
    step();

    for (int i = 0; i < 40; i++) begin
      r_st = 1'($urandom_range(0, 1));
      r_a  = $urandom & 32'hFFFF_FFFC;
      off  = $urandom_range(0, 3);
      r_lt = 4'd0;
      r_stt = 4'd0;
      if (r_st) begin
        r_stt = 4'($urandom_range(1, 3));
        if (r_stt == 4'd1) begin
          r_a = r_a + 32'(off); r_bv = 4'(1 << off);
        end else if (r_stt == 4'd2) begin
          off = off & 2; r_a = r_a + 32'(off); r_bv = 4'(3 << off);
        end else begin
          r_bv = 4'hF;
        end
      end else begin
        r_lt = 4'($urandom_range(1, 5));
        if (r_lt <= 4'd2) begin
          r_a = r_a + 32'(off); r_bv = 4'(1 << off);
        end else if (r_lt <= 4'd4) begin
          off = off & 2; r_a = r_a + 32'(off); r_bv = 4'(3 << off);
        end else begin
          r_bv = 4'hF;
        end
      end
      run_txn(r_st, r_lt, r_stt, r_bv, r_a, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
